// File: rtl/mpmp_fifo_push_arbiter.sv
// Round-robin arbiter sharing the N-lane push port of the multi-push/multi-pop FIFO
// between R requesters. A packet stays locked to its requester until its last word
// is accepted, so packets from different sources never interleave in the FIFO.
module mpmp_fifo_push_arbiter #(
  parameter  int W  = 16,
  parameter  int N  = 2,
  parameter  int R  = 3,
  localparam int WN = $clog2(N + 1),
  localparam int RW = (R > 1) ? $clog2(R) : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [R*WN-1:0]   req_cnt,
  input  logic [R*N*W-1:0]  req_data,
  input  logic [R-1:0]      req_last,
  output logic [R*WN-1:0]   ack_cnt,
  output logic [WN-1:0]     fifo_push,
  output logic [N*W-1:0]    fifo_push_data,
  input  logic [WN-1:0]     fifo_can_push,
  output logic              busy,
  output logic [RW-1:0]     owner
);

  typedef enum logic {IDLE, LOCKED} state_t;

  localparam logic [RW:0] R_EXT = (RW + 1)'(R);

  state_t          state_reg, state_next;
  logic [RW-1:0]   rr_ptr_reg, rr_ptr_next;
  logic [RW-1:0]   owner_reg, owner_next;

  logic [WN-1:0]   cnt_arr [R];
  logic [N*W-1:0]  data_arr [R];
  logic [RW-1:0]   win;
  logic            win_vld;
  logic [WN-1:0]   win_cnt;
  logic [N*W-1:0]  win_data;
  logic            win_last;
  logic [WN-1:0]   acc;
  logic            done;

  // Operands are always below 2R, so one conditional subtract is a full modulo R.
  function automatic logic [RW-1:0] wrap_idx(input logic [RW:0] v);
    logic [RW:0] t;
    t = (v >= R_EXT) ? (v - R_EXT) : v;
    return t[RW-1:0];
  endfunction

  genvar gi;

  // Split the flat request buses into per-requester views.
  generate
    for (gi = 0; gi < R; gi++) begin : g_unpack
      assign cnt_arr[gi]  = req_cnt[gi*WN +: WN];
      assign data_arr[gi] = req_data[gi*N*W +: N*W];
    end
  endgenerate

  // Winner: the lock owner while LOCKED, else the first requester from rr_ptr onward.
  always_comb begin
    win     = '0;
    win_vld = 1'b0;
    if (state_reg == LOCKED) begin
      win     = owner_reg;
      win_vld = 1'b1;
    end else begin
      for (int i = 0; i < R; i++) begin
        if (!win_vld && (cnt_arr[wrap_idx({1'b0, rr_ptr_reg} + (RW + 1)'(i))] != '0)) begin
          win     = wrap_idx({1'b0, rr_ptr_reg} + (RW + 1)'(i));
          win_vld = 1'b1;
        end
      end
    end
  end

  assign win_cnt  = cnt_arr[win];
  assign win_data = data_arr[win];
  assign win_last = req_last[win];

  // Accept as many words as both the winner offers and the FIFO can take.
  always_comb begin
    acc = '0;
    if (win_vld) begin
      acc = (win_cnt < fifo_can_push) ? win_cnt : fifo_can_push;
    end
  end

  // A packet only ends when every offered word, including the last one, goes in.
  assign done = (acc != '0) && (acc == win_cnt) && win_last;

  assign fifo_push = acc;

  // Per-requester acks: only the winner sees a nonzero count.
  generate
    for (gi = 0; gi < R; gi++) begin : g_ack
      assign ack_cnt[gi*WN +: WN] = (win_vld && (win == RW'(gi))) ? acc : '0;
    end
  endgenerate

  // Lanes beyond the accepted count are forced to zero.
  generate
    for (gi = 0; gi < N; gi++) begin : g_lane
      assign fifo_push_data[gi*W +: W] = (WN'(gi) < acc) ? win_data[gi*W +: W] : '0;
    end
  endgenerate

  // Next-state logic for the lock and the round-robin pointer.
  always_comb begin
    state_next  = state_reg;
    rr_ptr_next = rr_ptr_reg;
    owner_next  = owner_reg;
    case (state_reg)
      IDLE: begin
        if (acc != '0) begin
          if (done) begin
            rr_ptr_next = wrap_idx({1'b0, win} + (RW + 1)'(1));
          end else begin
            state_next = LOCKED;
            owner_next = win;
          end
        end
      end
      LOCKED: begin
        if (done) begin
          state_next  = IDLE;
          rr_ptr_next = wrap_idx({1'b0, owner_reg} + (RW + 1)'(1));
          owner_next  = '0;
        end
      end
      default: begin
        state_next = IDLE;
        owner_next = '0;
      end
    endcase
  end

  // State registers; reset drops any lock immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      owner_reg  <= '0;
    end else begin
      state_reg  <= state_next;
      rr_ptr_reg <= rr_ptr_next;
      owner_reg  <= owner_next;
    end
  end

  assign busy  = (state_reg == LOCKED);
  assign owner = owner_reg;

endmodule

// File: tb/tb_mpmp_fifo_push_arbiter.sv
// Directed bench for mpmp_fifo_push_arbiter with N=2, R=3 and a 16-deep FIFO
// occupancy model driving fifo_can_push.
module tb_mpmp_fifo_push_arbiter;

  localparam int W  = 16;
  localparam int N  = 2;
  localparam int R  = 3;
  localparam int WN = 2;
  localparam int RW = 2;
  localparam int D  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic [R*WN-1:0]   req_cnt;
  logic [R*N*W-1:0]  req_data;
  logic [R-1:0]      req_last;
  logic [R*WN-1:0]   ack_cnt;
  logic [WN-1:0]     fifo_push;
  logic [N*W-1:0]    fifo_push_data;
  logic [WN-1:0]     fifo_can_push;
  logic              busy;
  logic [RW-1:0]     owner;

  int n_total = 0;
  int n_pass  = 0;
  int occ;
  int exp_can;

  mpmp_fifo_push_arbiter #(.W(W), .N(N), .R(R)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_cnt        (req_cnt),
    .req_data       (req_data),
    .req_last       (req_last),
    .ack_cnt        (ack_cnt),
    .fifo_push      (fifo_push),
    .fifo_push_data (fifo_push_data),
    .fifo_can_push  (fifo_can_push),
    .busy           (busy),
    .owner          (owner)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, act, exp);
  endtask

  task automatic set_req(input int r, input int c, input logic [15:0] d0,
                         input logic [15:0] d1, input logic l);
    req_cnt[r*WN +: WN]       = WN'(c);
    req_data[(r*N)*W +: W]    = d0;
    req_data[(r*N+1)*W +: W]  = d1;
    req_last[r]               = l;
  endtask

  task automatic clr_req();
    req_cnt  = '0;
    req_data = '0;
    req_last = '0;
  endtask

  function automatic logic [31:0] ack1(input int r, input int a);
    return 32'(a) << (r * WN);
  endfunction

  // One line per transaction, then advance to just after the next rising edge.
  task automatic tick();
    $display("t=%0t can=%0d push=%0d data=%h ack=%h busy=%0d owner=%0d",
             $time, fifo_can_push, fifo_push, fifo_push_data, ack_cnt, busy, owner);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int exp_win [5];
    exp_win = '{1, 2, 0, 1, 2};
    rst = 1'b1;
    clr_req();
    fifo_can_push = '0;
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_owner", 32'(owner), 32'd0);
    check("rst_push", 32'(fifo_push), 32'd0);
    check("rst_ack", 32'(ack_cnt), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // T1: single full packet from R0.
    set_req(0, 2, 16'hA000, 16'hA001, 1'b1);
    fifo_can_push = 2'd2;
    #2;
    check("t1_ack", 32'(ack_cnt), ack1(0, 2));
    check("t1_push", 32'(fifo_push), 32'd2);
    check("t1_data", fifo_push_data, 32'hA001A000);
    tick();
    check("t1_busy", 32'(busy), 32'd0);

    // T2: rotation from rr_ptr=1; lane 1 must be masked.
    clr_req();
    for (int r = 0; r < R; r++) set_req(r, 1, 16'(16'h1000 + r), 16'hBEEF, 1'b1);
    for (int k = 0; k < 5; k++) begin
      #2;
      check($sformatf("t2_ack%0d", k), 32'(ack_cnt), ack1(exp_win[k], 1));
      check($sformatf("t2_push%0d", k), 32'(fifo_push), 32'd1);
      check($sformatf("t2_data%0d", k), fifo_push_data, 32'(16'h1000 + exp_win[k]));
      tick();
    end

    // T3: R0 alone moves rr_ptr to 1, then R1 locks a 5-word packet.
    clr_req();
    set_req(0, 1, 16'h2000, 16'h0000, 1'b1);
    #2;
    check("t3_pre_ack", 32'(ack_cnt), ack1(0, 1));
    tick();
    set_req(1, 2, 16'h3100, 16'h3101, 1'b0);
    #2;
    check("t3_a_ack", 32'(ack_cnt), ack1(1, 2));
    check("t3_a_data", fifo_push_data, 32'h31013100);
    tick();
    check("t3_a_busy", 32'(busy), 32'd1);
    check("t3_a_owner", 32'(owner), 32'd1);
    set_req(1, 2, 16'h3102, 16'h3103, 1'b0);
    #2;
    check("t3_b_ack", 32'(ack_cnt), ack1(1, 2));
    tick();
    check("t3_b_busy", 32'(busy), 32'd1);
    check("t3_b_owner", 32'(owner), 32'd1);
    set_req(1, 0, 16'h0000, 16'h0000, 1'b0);
    #2;
    check("t3_gap_ack", 32'(ack_cnt), 32'd0);
    check("t3_gap_push", 32'(fifo_push), 32'd0);
    tick();
    check("t3_gap_busy", 32'(busy), 32'd1);
    set_req(1, 1, 16'h3104, 16'h0000, 1'b1);
    #2;
    check("t3_c_ack", 32'(ack_cnt), ack1(1, 1));
    check("t3_c_push", 32'(fifo_push), 32'd1);
    tick();
    check("t3_c_busy", 32'(busy), 32'd0);
    check("t3_c_owner", 32'(owner), 32'd0);
    set_req(1, 0, 16'h0000, 16'h0000, 1'b0);
    #2;
    check("t3_d_ack", 32'(ack_cnt), ack1(0, 1));
    check("t3_d_data", fifo_push_data, 32'h00002000);
    tick();

    // T4: partial accept with can_push=1 locks R2.
    clr_req();
    fifo_can_push = 2'd1;
    set_req(2, 2, 16'h4000, 16'h4001, 1'b1);
    #2;
    check("t4_a_ack", 32'(ack_cnt), ack1(2, 1));
    check("t4_a_data", fifo_push_data, 32'h00004000);
    tick();
    check("t4_a_busy", 32'(busy), 32'd1);
    check("t4_a_owner", 32'(owner), 32'd2);
    set_req(2, 1, 16'h4001, 16'h0000, 1'b1);
    #2;
    check("t4_b_ack", 32'(ack_cnt), ack1(2, 1));
    check("t4_b_data", fifo_push_data, 32'h00004001);
    tick();
    check("t4_b_busy", 32'(busy), 32'd0);

    // T5: FIFO full - nothing moves; then rr_ptr=0 lets R0 win.
    fifo_can_push = 2'd0;
    for (int r = 0; r < R; r++) set_req(r, 2, 16'(16'h5000 + r), 16'(16'h5100 + r), 1'b1);
    for (int k = 0; k < 4; k++) begin
      #2;
      check($sformatf("t5_ack%0d", k), 32'(ack_cnt), 32'd0);
      check($sformatf("t5_push%0d", k), 32'(fifo_push), 32'd0);
      tick();
      check($sformatf("t5_busy%0d", k), 32'(busy), 32'd0);
    end
    fifo_can_push = 2'd2;
    #2;
    check("t5_resume_ack", 32'(ack_cnt), ack1(0, 2));
    check("t5_resume_data", fifo_push_data, 32'h51005000);
    tick();

    // Fill a 16-deep FIFO model; push must track the remaining room exactly.
    occ = 0;
    for (int k = 0; k < 10; k++) begin
      exp_can = (D - occ < N) ? D - occ : N;
      fifo_can_push = WN'(exp_can);
      #2;
      check($sformatf("fill_push%0d", k), 32'(fifo_push), 32'(exp_can));
      occ += int'(fifo_push);
      tick();
    end
    check("fill_occ", 32'(occ), 32'(D));

    // T6: asynchronous reset while R2 holds the lock.
    clr_req();
    fifo_can_push = 2'd2;
    set_req(2, 2, 16'h6000, 16'h6001, 1'b0);
    #2;
    check("t6_ack", 32'(ack_cnt), ack1(2, 2));
    tick();
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_owner", 32'(owner), 32'd2);
    rst = 1'b1;
    #1;
    check("t6_rst_busy", 32'(busy), 32'd0);
    check("t6_rst_owner", 32'(owner), 32'd0);
    #2;
    rst = 1'b0;
    set_req(0, 1, 16'h6100, 16'h0000, 1'b1);
    set_req(2, 1, 16'h6002, 16'h0000, 1'b1);
    #2;
    check("t6_post_ack", 32'(ack_cnt), ack1(0, 1));
    check("t6_post_data", fifo_push_data, 32'h00006100);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
